timer_counter: RTL

Memory-mapped programmable timer serving as device 0 behind the system bridge, decoded in the 0x0000_7F00–0x0000_7F0B window. It accepts CPU register writes and returns register reads over the bridge's device port, counts down from a preset value, and raises an interrupt request toward the CP0 hardware-interrupt inputs. It supports a one-shot mode and an auto-reload mode.

---
 rtl/timer_defs.sv | 25 ++
 rtl/timer_counter.sv | 115 +++++++++++
 2 files changed

// File: rtl/timer_defs.sv
// Shared constants for the memory-mapped countdown timer: register word offsets,
// CTRL bit positions, MODE codes and FSM state encoding.
package timer_defs;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlModeLo = 1;
  localparam int unsigned CtrlModeHi = 2;
  localparam int unsigned CtrlImBit  = 3;

  // Codes 2 and 3 fall back to one-shot behaviour.
  localparam logic [1:0] ModeOneShot = 2'd0;
  localparam logic [1:0] ModeReload  = 2'd1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable countdown timer with one-shot and auto-reload modes, a CTRL/PRESET/COUNT
// register window and a maskable level interrupt.
module timer_counter
  import timer_defs::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               irq
);

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic [1:0]           mode_q, mode_d;
  logic                 im_q, im_d;
  logic                 flag_q, flag_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      flag_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      flag_q   <= flag_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  // FSM first, then CPU writes, so a CTRL write overrides the one-shot EN clear.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > COUNT_W'(1)) begin
          count_d = count_q - COUNT_W'(1);
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (mode_q == ModeReload) begin
          flag_d  = 1'b0;
          state_d = StLoad;
        end else begin
          en_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (we) begin
      unique case (addr[3:2])
        RegCtrl: begin
          en_d   = wd[CtrlEnBit];
          mode_d = wd[CtrlModeHi:CtrlModeLo];
          im_d   = wd[CtrlImBit];
          flag_d = 1'b0;
        end
        RegPreset: preset_d = wd[COUNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    unique case (addr[3:2])
      RegCtrl:   rd = {28'd0, im_q, mode_q, en_q};
      RegPreset: rd = 32'(preset_q);
      RegCount:  rd = 32'(count_q);
      default:   rd = '0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule
